fetch_queue: RTL

- Parametrised instruction-fetch front end. Successor to the single PC / PC_adder / IF-mux path.
- Generates the fetch PC and reads a combinational ROM. Buffers fetched instructions in a DEPTH-entry prefetch FIFO.
- Presents the head entry to IF_ID under a valid/ready handshake. ID-stage stalls no longer freeze fetch.
- A taken branch flushes the queue and redirects fetch.

---
 rtl/fetch_queue.sv | 106 ++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: fetch PC, combinational ROM read, DEPTH-entry prefetch FIFO
// with valid/ready handoff to IF_ID and branch flush. Optional macro FQ_BYPASS_EN: empty-queue bypass.
module fetch_queue #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int PC_STEP = 4
) (
  input  logic                     clk,
  input  logic                     R,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [DATA_W-1:0]        rom_data,
  input  logic                     branch_taken,
  input  logic [ADDR_W-1:0]        branch_target,
  input  logic                     id_ready,
  output logic                     if_valid,
  output logic [DATA_W-1:0]        if_instr,
  output logic [ADDR_W-1:0]        if_pc_plus_4,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(PC_STEP);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Storage is deliberately not reset; slots are only meaningful while counted.
  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [ADDR_W-1:0] pc4_mem   [DEPTH];

  logic head_valid;
  logic bypass;
  logic pop;
  logic push;
  logic [ADDR_W-1:0] next_pc;

  assign next_pc    = fetch_pc_q + STEP;
  assign head_valid = (count_q != '0);

`ifdef FQ_BYPASS_EN
  assign bypass = (count_q == '0) & ~branch_taken & id_ready;
`else
  assign bypass = 1'b0;
`endif

  assign pop  = head_valid & id_ready & ~branch_taken;
  assign push = ~branch_taken & ~bypass & ((count_q < FULL_CNT) | pop);

  assign rom_addr     = fetch_pc_q;
  assign count        = count_q;
  assign if_valid     = head_valid | bypass;
  assign if_instr     = bypass ? rom_data : instr_mem[rd_ptr_q];
  assign if_pc_plus_4 = bypass ? next_pc  : pc4_mem[rd_ptr_q];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (branch_taken) begin
      // Flush wins over everything; the head is dropped, not consumed.
      fetch_pc_d = branch_target;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push || bypass) fetch_pc_d = next_pc;
      if (push)           wr_ptr_d   = wr_ptr_q + PTR_ONE;
      if (pop)            rd_ptr_d   = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      fetch_pc_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= rom_data;
      pc4_mem[wr_ptr_q]   <= next_pc;
    end
  end

endmodule
